ave8_level_mon: RTL and testbench

//  Downstream consumer of the 8-sample moving-average stage. Watches each new average

---
 rtl/ave8_level_mon.sv | 180 ++++++++++++++++++
 tb/tb_ave8_level_mon.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ave8_level_mon.sv
// Level alarm for the 8-sample moving average: hysteresis, debounce and a
// one-entry RISE/FALL event buffer with sticky overflow.
module ave8_level_mon #(
    parameter logic [7:0] HI_TH    = 8'd200,
    parameter logic [7:0] LO_TH    = 8'd150,
    parameter int         DEBOUNCE = 3,
    parameter int         DUR_W    = 12
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [7:0]       ave_in,
    input  logic             ave_vld,
    input  logic             evt_ready,
    output logic             alarm,
    output logic             evt_valid,
    output logic             evt_type,
    output logic [7:0]       evt_peak,
    output logic [DUR_W-1:0] evt_dur,
    output logic             ovf
);

    localparam logic [3:0]       DEB     = 4'(DEBOUNCE);
    localparam logic [DUR_W-1:0] DUR_MAX = '1;
    localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ALARM,
        DISARM
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       peak_q, peak_d;
    logic [DUR_W-1:0] dur_q, dur_d;

    logic             gen;
    logic             gen_type;
    logic [7:0]       gen_peak;
    logic [DUR_W-1:0] gen_dur;
    logic             load;

    logic             is_hi;
    logic             is_lo;
    logic [3:0]       cnt_inc;
    logic [7:0]       peak_upd;
    logic [DUR_W-1:0] dur_upd;

    assign is_hi    = (ave_in >= HI_TH);
    assign is_lo    = (ave_in <= LO_TH);
    assign cnt_inc  = cnt_q + 4'd1;
    assign peak_upd = (ave_in > peak_q) ? ave_in : peak_q;
    assign dur_upd  = (dur_q == DUR_MAX) ? dur_q : dur_q + DUR_ONE;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            peak_q  <= 8'd0;
            dur_q   <= '0;
            alarm   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            peak_q  <= peak_d;
            dur_q   <= dur_d;
            alarm   <= (state_d == ALARM) || (state_d == DISARM);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        peak_d   = peak_q;
        dur_d    = dur_q;
        gen      = 1'b0;
        gen_type = 1'b0;
        gen_peak = 8'd0;
        gen_dur  = '0;
        if (ave_vld) begin
            unique case (state_q)
                IDLE: begin
                    if (is_hi) begin
                        if (DEB == 4'd1) begin
                            state_d  = ALARM;
                            cnt_d    = 4'd0;
                            peak_d   = ave_in;
                            dur_d    = DUR_ONE;
                            gen      = 1'b1;
                            gen_peak = ave_in;
                        end else begin
                            state_d = ARM;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                ARM: begin
                    if (!is_hi) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else if (cnt_inc == DEB) begin
                        state_d  = ALARM;
                        cnt_d    = 4'd0;
                        peak_d   = ave_in;
                        dur_d    = DUR_ONE;
                        gen      = 1'b1;
                        gen_peak = ave_in;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ALARM: begin
                    peak_d = peak_upd;
                    dur_d  = dur_upd;
                    if (!is_lo) begin
                        cnt_d = 4'd0;
                    end else if (DEB == 4'd1) begin
                        state_d  = IDLE;
                        cnt_d    = 4'd0;
                        gen      = 1'b1;
                        gen_type = 1'b1;
                        gen_peak = peak_upd;
                        gen_dur  = dur_upd;
                    end else begin
                        state_d = DISARM;
                        cnt_d   = 4'd1;
                    end
                end
                DISARM: begin
                    peak_d = peak_upd;
                    dur_d  = dur_upd;
                    if (!is_lo) begin
                        state_d = ALARM;
                        cnt_d   = 4'd0;
                    end else if (cnt_inc == DEB) begin
                        state_d  = IDLE;
                        cnt_d    = 4'd0;
                        gen      = 1'b1;
                        gen_type = 1'b1;
                        gen_peak = peak_upd;
                        gen_dur  = dur_upd;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // A handshake in the same cycle frees the slot for the new record.
    assign load = gen && (!evt_valid || evt_ready);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            evt_valid <= 1'b0;
            evt_type  <= 1'b0;
            evt_peak  <= 8'd0;
            evt_dur   <= '0;
            ovf       <= 1'b0;
        end else if (load) begin
            evt_valid <= 1'b1;
            evt_type  <= gen_type;
            evt_peak  <= gen_peak;
            evt_dur   <= gen_dur;
        end else begin
            if (gen) begin
                ovf <= 1'b1;
            end
            if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ave8_level_mon.sv
// Directed bench for ave8_level_mon: arming, glitches, episodes,
// backpressure/overflow, reset mid-episode and duration saturation.
module tb_ave8_level_mon;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  ave_in = 8'd0;
    logic        ave_vld = 1'b0;
    logic        evt_ready = 1'b1;

    logic        alarm, evt_valid, evt_type, ovf;
    logic [7:0]  evt_peak;
    logic [11:0] evt_dur;

    logic        s_alarm, s_evt_valid, s_evt_type, s_ovf;
    logic [7:0]  s_evt_peak;
    logic [2:0]  s_evt_dur;

    int total = 0;
    int bad = 0;
    int n_evt = 0;
    int snap;

    ave8_level_mon dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .ave_in(ave_in), .ave_vld(ave_vld), .evt_ready(evt_ready),
        .alarm(alarm), .evt_valid(evt_valid), .evt_type(evt_type),
        .evt_peak(evt_peak), .evt_dur(evt_dur), .ovf(ovf)
    );

    ave8_level_mon #(.DUR_W(3)) u_sat (
        .CLOCK(CLOCK), .RESET(RESET),
        .ave_in(ave_in), .ave_vld(ave_vld), .evt_ready(evt_ready),
        .alarm(s_alarm), .evt_valid(s_evt_valid), .evt_type(s_evt_type),
        .evt_peak(s_evt_peak), .evt_dur(s_evt_dur), .ovf(s_ovf)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) begin
        if (evt_valid && evt_ready) n_evt <= n_evt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic check_evt(input string tag, input int typ,
                             input int peak, input int dur);
        check({tag, "_vld"}, 32'(evt_valid), 1);
        check({tag, "_type"}, 32'(evt_type), typ);
        check({tag, "_peak"}, 32'(evt_peak), peak);
        check({tag, "_dur"}, 32'(evt_dur), dur);
    endtask

    task automatic strobe(input logic [7:0] v);
        ave_in = v;
        ave_vld = 1'b1;
        @(negedge CLOCK);
        ave_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic feed(input logic [7:0] v);
        strobe(v);
        idle(2);
    endtask

    initial begin
        #1;
        check("rst_alarm", 32'(alarm), 0);
        check("rst_vld", 32'(evt_valid), 0);
        check("rst_type", 32'(evt_type), 0);
        check("rst_peak", 32'(evt_peak), 0);
        check("rst_dur", 32'(evt_dur), 0);
        check("rst_ovf", 32'(ovf), 0);
        @(negedge CLOCK);
        RESET = 1'b0;
        idle(1);

        // T1 arm
        feed(210); feed(210);
        check("t1_pre", 32'(alarm), 0);
        strobe(210);
        check("t1_alarm", 32'(alarm), 1);
        check_evt("t1_rise", 0, 210, 0);
        idle(2);
        check("t1_drop", 32'(evt_valid), 0);
        check("t1_cnt", 32'(n_evt), 1);
        feed(140); feed(140);
        strobe(140);
        check("t1_clr", 32'(alarm), 0);
        check_evt("t1_fall", 1, 210, 4);
        idle(2);
        check("t1_cnt2", 32'(n_evt), 2);

        // T2 glitch, then 200 counts as high
        feed(210); feed(210); feed(199); feed(210); feed(210);
        check("t2_alarm", 32'(alarm), 0);
        check("t2_vld", 32'(evt_valid), 0);
        check("t2_cnt", 32'(n_evt), 2);
        feed(100); feed(200); feed(200);
        check("t2_pre", 32'(alarm), 0);
        strobe(200);
        check("t2_alarm2", 32'(alarm), 1);
        check_evt("t2_rise", 0, 200, 0);
        idle(2);
        feed(140); feed(140);
        strobe(140);
        check_evt("t2_fall", 1, 200, 4);
        idle(2);

        // T3 full episode
        feed(210); feed(210); feed(210); feed(230);
        feed(180); feed(140); feed(140);
        check("t3_pre", 32'(alarm), 1);
        strobe(140);
        check("t3_alarm", 32'(alarm), 0);
        check_evt("t3_fall", 1, 230, 6);
        idle(2);

        // T4 clear glitch
        feed(210); feed(210); feed(210);
        feed(140); feed(140); feed(160); feed(140);
        strobe(140);
        check("t4_hold", 32'(alarm), 1);
        check("t4_novld", 32'(evt_valid), 0);
        idle(2);
        strobe(140);
        check("t4_alarm", 32'(alarm), 0);
        check_evt("t4_fall", 1, 210, 7);
        idle(2);

        // T5 backpressure
        evt_ready = 1'b0;
        feed(210); feed(210);
        strobe(210);
        check_evt("t5_rise", 0, 210, 0);
        idle(2);
        feed(230); feed(180); feed(140); feed(140);
        strobe(140);
        check("t5_alarm", 32'(alarm), 0);
        check_evt("t5_held", 0, 210, 0);
        check("t5_ovf", 32'(ovf), 1);
        idle(2);
        snap = n_evt;
        evt_ready = 1'b1;
        @(negedge CLOCK);
        check("t5_vld", 32'(evt_valid), 0);
        check("t5_ovf2", 32'(ovf), 1);
        check("t5_acc", 32'(n_evt), snap + 1);
        idle(1);

        // T6 reset in ALARM
        evt_ready = 1'b0;
        feed(210); feed(210);
        strobe(210);
        check("t6_alarm", 32'(alarm), 1);
        check("t6_vld", 32'(evt_valid), 1);
        idle(1);
        RESET = 1'b1;
        #1;
        check("t6_r_alarm", 32'(alarm), 0);
        check("t6_r_vld", 32'(evt_valid), 0);
        check("t6_r_ovf", 32'(ovf), 0);
        check("t6_r_peak", 32'(evt_peak), 0);
        @(negedge CLOCK);
        RESET = 1'b0;
        evt_ready = 1'b1;
        idle(1);
        feed(210); feed(210);
        check("t6_pre", 32'(alarm), 0);
        strobe(210);
        check("t6_alarm2", 32'(alarm), 1);
        check_evt("t6_rise", 0, 210, 0);
        idle(2);
        feed(140); feed(140); feed(140);

        // duration saturation on the DUR_W=3 instance
        repeat (7) feed(210);
        feed(140); feed(140);
        strobe(140);
        check_evt("sat_main", 1, 210, 8);
        check("sat_vld", 32'(s_evt_valid), 1);
        check("sat_dur", 32'(s_evt_dur), 7);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
